fifo_wr_arbiter: RTL and testbench

// Round-robin arbiter sharing the async_fifo write port among NUM_REQ byte

---
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the async_fifo write port; 0-cycle data path, 1 bubble between grants.
// Backpressure: fifo_full drops req_ready/fifo_wr_en of the owner and freezes the beat count; the grant is held.
module fifo_wr_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_BURST  = 4,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BCW        = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

    logic           pick_vld;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] cand;
    logic           beat;
    logic           release_grant;

    assign beat          = (state_q == GRANT) && req_valid[grant_id_q] && !fifo_full;
    assign release_grant = beat && (req_last[grant_id_q] || (beat_cnt_q == BCW'(MAX_BURST - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // First valid requester at or above rr_ptr, wrapping; fifo_full is deliberately ignored here.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d    = GRANT;
                    grant_id_d = pick_id;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        busy       = 1'b0;
        if (state_q == GRANT) begin
            busy                  = 1'b1;
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_en            = beat;
            fifo_din              = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: burst queues per requester, a transaction-level round-robin model
// feeding a write scoreboard, an emulated 16-deep FIFO for fill/stall, and a directed reset-mid-burst case.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int MAXB  = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic [1:0]        grant_id;
    logic              busy;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NREQ), .MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       e;
        logic [1:0] id;
        logic [7:0] d;
    } exp_t;

    exp_t       sb_q[$];
    logic [8:0] src_q[NREQ][$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         model_ptr = 0;
    int         occ = 0;
    bit         mon_en = 1'b0;
    bit         expect_idle = 1'b0;
    exp_t       h;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Reference order: round robin over non-empty queues, each grant takes bytes until last or MAXB.
    task automatic build_expect();
        logic [8:0] m[NREQ][$];
        logic [8:0] b;
        int owner;
        int n;
        bit fin;
        for (int i = 0; i < NREQ; i++) m[i] = src_q[i];
        forever begin
            owner = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (owner < 0 && m[(model_ptr + k) % NREQ].size() > 0) owner = (model_ptr + k) % NREQ;
            end
            if (owner < 0) break;
            n = 0;
            fin = 1'b0;
            while (!fin) begin
                b = m[owner].pop_front();
                n++;
                fin = b[8] || (n == MAXB);
                sb_q.push_back({fin, 2'(owner), b[7:0]});
            end
            model_ptr = (owner + 1) % NREQ;
        end
    endtask

    task automatic add_burst(input int i, inout int total);
        int len;
        len = $urandom_range(1, 6);
        for (int k = 0; k < len; k++) src_q[i].push_back({(k == len - 1), 8'($urandom)});
        total += len;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                req_data[i*DW +: DW] = src_q[i][0][7:0];
                req_last[i]          = src_q[i][0][8];
                req_valid[i]         = !(busy && (grant_id == 2'(i)) && ($urandom_range(0, 3) == 0));
            end else begin
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
                req_valid[i]         = 1'b0;
            end
        end
    endtask

    task automatic run_round(input int rd_pct, input int hold, input int min_total);
        int total = 0;
        int cyc = 0;
        int nb;
        bit pending;
        logic [NREQ-1:0] hs;
        logic wr;
        int rd;
        for (int i = 0; i < NREQ; i++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) add_burst(i, total);
        end
        while (total < min_total) add_burst($urandom_range(0, NREQ - 1), total);
        build_expect();
        pending = 1'b1;
        while (pending && cyc < 4000) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            wr = fifo_wr_en;
            if (hold > 0 && cyc == hold - 1) chk("fifo_fill_stall_occ", occ, DEPTH);
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) if (hs[i]) void'(src_q[i].pop_front());
            rd = (cyc >= hold && occ > 0 && $urandom_range(0, 99) < rd_pct) ? 1 : 0;
            occ = occ + int'(wr) - rd;
            fifo_full = (occ >= DEPTH) || ($urandom_range(0, 9) == 0);
            drive_inputs();
            cyc++;
            pending = (sb_q.size() > 0);
            for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) pending = 1'b1;
        end
        if (pending) fail_now("round_timeout");
    endtask

    // Scoreboard monitor: while busy, the head of the expected stream names the owner and its byte.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (expect_idle) begin
                    chk("bubble_busy", busy, 0);
                    expect_idle = 1'b0;
                end
                if (busy) begin
                    if (sb_q.size() == 0) begin
                        fail_now("grant_without_pending_data");
                    end else begin
                        h = sb_q[0];
                        chk("grant_id", grant_id, h.id);
                        chk("req_ready", req_ready, fifo_full ? 4'b0 : (4'b0001 << h.id));
                        chk("fifo_wr_en", fifo_wr_en, !fifo_full && req_valid[h.id]);
                        chk("fifo_din", fifo_din, h.d);
                        if (fifo_wr_en) begin
                            void'(sb_q.pop_front());
                            if (h.e) expect_idle = 1'b1;
                        end
                    end
                end else begin
                    chk("idle_wr_en", fifo_wr_en, 0);
                    chk("idle_ready", req_ready, 0);
                    chk("idle_din", fifo_din, 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_grant_id", grant_id, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_round(60, 0, 0);
        run_round(30, 0, 0);
        run_round(50, 80, 20);
        run_round(80, 0, 0);

        @(negedge clk);
        mon_en    = 1'b0;
        fifo_full = 1'b0;

        // Single-beat burst from req2 leaves rr_ptr at 3, so a stale pointer after reset would pick req3.
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        req_data  = {8'h00, 8'h77, 8'h00, 8'h00};
        @(posedge clk); #1;
        chk("t1_pre_grant", {busy, grant_id}, {1'b1, 2'd2});
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        req_data  = {8'h00, 8'h00, 8'h55, 8'h00};
        @(posedge clk); #1;
        chk("t1_mid_busy", busy, 1);
        chk("t1_mid_grant_id", grant_id, 1);
        chk("t1_mid_wr_en", fifo_wr_en, 1);
        chk("t1_mid_din", fifo_din, 8'h55);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_wr_en", fifo_wr_en, 0);
        chk("t1_rst_ready", req_ready, 0);
        chk("t1_rst_din", fifo_din, 0);
        req_valid = 4'b1100;
        req_data  = {8'h33, 8'h22, 8'h00, 8'h00};
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t1_after_grant_id", grant_id, 2);
        chk("t1_after_busy", busy, 1);
        chk("t1_after_din", fifo_din, 8'h22);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
